anim_sequencer: RTL and testbench

//   Per-fighter animation sequencer. Turns movement/attack requests and hit events into the
//   (anim_state, anim_frame) pair consumed by the downstream sprite-ID lookup.

---
 rtl/anim_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_anim_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/anim_sequencer.sv
// Per-fighter animation sequencer: turns movement/attack requests and hit events into
// the (anim_state, anim_frame) pair, with attack/hitstun lockout and attack active window.
module anim_sequencer #(
    parameter int ATK1_FRAMES   = 4,
    parameter int ATK2_FRAMES   = 6,
    parameter int FRAME_HOLD    = 4,
    parameter int HITSTUN_TICKS = 20,
    parameter int ATK1_ACT_LO   = 2,
    parameter int ATK1_ACT_HI   = 2,
    parameter int ATK2_ACT_LO   = 2,
    parameter int ATK2_ACT_HI   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_move,
    input  logic       req_jump,
    input  logic       req_atk1,
    input  logic       req_atk2,
    input  logic       on_ground,
    input  logic       hit,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       busy,
    output logic       atk_active,
    output logic       anim_done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WALK = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5
    } state_t;

    localparam int HOLD_MAX = (FRAME_HOLD > HITSTUN_TICKS) ? FRAME_HOLD : HITSTUN_TICKS;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [HW-1:0] HIT_LOAD  = HW'(HITSTUN_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
    localparam logic [5:0]    ATK1_LAST = 6'(ATK1_FRAMES - 1);
    localparam logic [5:0]    ATK2_LAST = 6'(ATK2_FRAMES - 1);
    localparam logic [5:0]    A1_LO     = 6'(ATK1_ACT_LO);
    localparam logic [5:0]    A1_HI     = 6'(ATK1_ACT_HI);
    localparam logic [5:0]    A2_LO     = 6'(ATK2_ACT_LO);
    localparam logic [5:0]    A2_HI     = 6'(ATK2_ACT_HI);

    state_t        state_r;
    logic [5:0]    frame_r;
    logic [HW-1:0] hold_r;
    logic          hit_pending_r;
    logic          jump_armed_r;
    logic          done_r;

    state_t        exit_state_s;
    logic [5:0]    last_frame_s;

    // Where a finished attack or hitstun lands, and the last frame of the current attack
    always_comb begin
        if (!on_ground) begin
            exit_state_s = S_JUMP;
        end else if (req_move) begin
            exit_state_s = S_WALK;
        end else begin
            exit_state_s = S_IDLE;
        end
        if (state_r == S_ATK2) begin
            last_frame_s = ATK2_LAST;
        end else begin
            last_frame_s = ATK1_LAST;
        end
    end

    // Sequencer state, frame, hold counter and hit latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            frame_r       <= 6'd0;
            hold_r        <= HOLD_ZERO;
            hit_pending_r <= 1'b0;
            jump_armed_r  <= 1'b0;
            done_r        <= 1'b0;
        end else if (!tick) begin
            done_r <= 1'b0;
            if (hit) begin
                hit_pending_r <= 1'b1;
            end else begin
                hit_pending_r <= hit_pending_r;
            end
        end else begin
            done_r        <= 1'b0;
            hit_pending_r <= 1'b0;
            if (hit || hit_pending_r) begin
                state_r <= S_HIT;
                frame_r <= 6'd0;
                hold_r  <= HIT_LOAD;
            end else begin
                case (state_r)
                    S_HIT: begin
                        if (hold_r == HOLD_ONE) begin
                            state_r      <= exit_state_s;
                            hold_r       <= HOLD_ZERO;
                            jump_armed_r <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            hold_r <= hold_r - HOLD_ONE;
                        end
                    end
                    S_ATK1, S_ATK2: begin
                        if (hold_r == HOLD_LAST) begin
                            hold_r <= HOLD_ZERO;
                            if (frame_r == last_frame_s) begin
                                state_r      <= exit_state_s;
                                frame_r      <= 6'd0;
                                jump_armed_r <= 1'b0;
                                done_r       <= 1'b1;
                            end else begin
                                frame_r <= frame_r + 6'd1;
                            end
                        end else begin
                            hold_r <= hold_r + HOLD_ONE;
                        end
                    end
                    S_IDLE, S_WALK: begin
                        frame_r <= 6'd0;
                        hold_r  <= HOLD_ZERO;
                        if (req_atk2) begin
                            state_r <= S_ATK2;
                        end else if (req_atk1) begin
                            state_r <= S_ATK1;
                        end else if ((req_jump && on_ground) || !on_ground) begin
                            state_r      <= S_JUMP;
                            jump_armed_r <= 1'b0;
                        end else if (req_move) begin
                            state_r <= S_WALK;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_JUMP: begin
                        if (on_ground && jump_armed_r) begin
                            state_r <= req_move ? S_WALK : S_IDLE;
                        end else if (!on_ground) begin
                            jump_armed_r <= 1'b1;
                        end else begin
                            jump_armed_r <= jump_armed_r;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                        frame_r <= 6'd0;
                        hold_r  <= HOLD_ZERO;
                    end
                endcase
            end
        end
    end

    // Lockout and hit-window decode of the registered state/frame
    always_comb begin
        case (state_r)
            S_ATK1: begin
                busy       = 1'b1;
                atk_active = (frame_r >= A1_LO) && (frame_r <= A1_HI);
            end
            S_ATK2: begin
                busy       = 1'b1;
                atk_active = (frame_r >= A2_LO) && (frame_r <= A2_HI);
            end
            S_HIT: begin
                busy       = 1'b1;
                atk_active = 1'b0;
            end
            default: begin
                busy       = 1'b0;
                atk_active = 1'b0;
            end
        endcase
    end

    assign anim_state = state_r;
    assign anim_frame = frame_r;
    assign anim_done  = done_r;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed vector table, hand-written corner
// sequences, and randomized stimulus compared against an elapsed-time reference model.
module tb_anim_sequencer;

    localparam int N1 = 4, N2 = 6, H = 4, HS = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, req_move = 1'b0, req_jump = 1'b0;
    logic       req_atk1 = 1'b0, req_atk2 = 1'b0, on_ground = 1'b1, hit = 1'b0;
    logic [3:0] anim_state;
    logic [5:0] anim_frame;
    logic       busy, atk_active, anim_done;

    int n_vec = 0;
    int n_err = 0;

    // reference model: state, elapsed attack ticks, remaining hitstun ticks
    int m_state = 0, m_el = 0, m_rem = 0;
    bit m_pend = 1'b0, m_armed = 1'b0, m_done = 1'b0;

    anim_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .req_move(req_move), .req_jump(req_jump),
        .req_atk1(req_atk1), .req_atk2(req_atk2), .on_ground(on_ground), .hit(hit),
        .anim_state(anim_state), .anim_frame(anim_frame), .busy(busy),
        .atk_active(atk_active), .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_exit();
        m_done = 1'b1;
        m_el   = 0;
        if (!on_ground) begin
            m_state = 2;
            m_armed = 1'b0;
        end else begin
            m_state = req_move ? 1 : 0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_el = 0; m_rem = 0; m_pend = 1'b0; m_armed = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!tick) begin
                if (hit) m_pend = 1'b1;
            end else if (hit || m_pend) begin
                m_pend = 1'b0; m_state = 5; m_rem = HS; m_el = 0;
            end else begin
                case (m_state)
                    5: begin m_rem--; if (m_rem == 0) m_exit(); end
                    3, 4: begin
                        m_el++;
                        if (m_el == ((m_state == 3) ? N1 : N2) * H) m_exit();
                    end
                    0, 1: begin
                        m_el = 0;
                        if (req_atk2) m_state = 4;
                        else if (req_atk1) m_state = 3;
                        else if (!on_ground || req_jump) begin m_state = 2; m_armed = 1'b0; end
                        else m_state = req_move ? 1 : 0;
                    end
                    default: begin
                        if (on_ground && m_armed) m_state = req_move ? 1 : 0;
                        else if (!on_ground) m_armed = 1'b1;
                    end
                endcase
            end
        end
    endtask

    task automatic model_check();
        int f;
        int act;
        f   = (m_state == 3 || m_state == 4) ? m_el / H : 0;
        act = (m_state == 3) ? int'(f == 2) : (m_state == 4) ? int'(f >= 2 && f <= 4) : 0;
        chk("model_state", anim_state, m_state);
        chk("model_frame", anim_frame, f);
        chk("model_busy", busy, int'(m_state >= 3));
        chk("model_active", atk_active, act);
        chk("model_done", anim_done, m_done);
    endtask

    // one clock with the given inputs; outputs sampled 1 time unit after the edge
    task automatic cyc(input bit r, input bit t, input bit h, input bit mv, input bit jp,
                       input bit a1, input bit a2, input bit og);
        rst = r; tick = t; hit = h; req_move = mv; req_jump = jp;
        req_atk1 = a1; req_atk2 = a2; on_ground = og;
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic tk(input bit mv, input bit jp, input bit a1, input bit a2, input bit og);
        cyc(1'b0, 1'b1, 1'b0, mv, jp, a1, a2, og);
        cyc(1'b0, 1'b0, 1'b0, mv, jp, a1, a2, og);
    endtask

    typedef struct {
        bit t, h, mv, jp, a1, a2, og;
        int st, fr, bz, ac, dn;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1,0,0,1,0,0,1, 2,0,0,0,0};
        tbl[1] = '{1,0,0,0,0,0,1, 2,0,0,0,0};
        tbl[2] = '{1,0,0,0,1,0,0, 2,0,0,0,0};
        tbl[3] = '{1,0,1,0,0,0,1, 1,0,0,0,0};
        tbl[4] = '{1,0,0,0,0,0,0, 2,0,0,0,0};
        tbl[5] = '{0,1,0,0,0,0,0, 2,0,0,0,0};
        tbl[6] = '{1,0,0,0,0,0,0, 5,0,1,0,0};
        tbl[7] = '{1,0,0,0,1,0,1, 5,0,1,0,0};

        // reset, then quiet ticks
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_state", anim_state, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            tk(0, 0, 0, 0, 1);
            chk("idle_state", anim_state, 0);
            chk("idle_done", anim_done, 0);
        end

        // attack 1 full run
        cyc(0, 1, 0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            chk("atk1_state", anim_state, 3);
            chk("atk1_frame", anim_frame, (k - 1) / 4);
            chk("atk1_active", atk_active, int'((k - 1) / 4 == 2));
            cyc(0, 0, 0, 0, 0, 0, 0, 1);
            cyc(0, 1, 0, 0, 0, 0, 0, 1);
        end
        chk("atk1_end_state", anim_state, 0);
        chk("atk1_done", anim_done, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("atk1_done_pulse", anim_done, 0);

        // attack 2 interrupted by a between-tick hit
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 12; k++) tk(0, 0, 0, 0, 1);
        chk("atk2_frame3", anim_frame, 3);
        chk("atk2_active", atk_active, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        chk("atk2_pending_hold", anim_state, 4);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("hit_state", anim_state, 5);
        chk("hit_frame", anim_frame, 0);
        chk("hit_busy", busy, 1);
        for (int k = 0; k < 19; k++) tk(0, 0, 0, 0, 1);
        chk("hit_still", anim_state, 5);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("hit_exit", anim_state, 0);
        chk("hit_done", anim_done, 1);

        // jump sequence table
        for (int i = 0; i < 8; i++) begin
            cyc(0, tbl[i].t, tbl[i].h, tbl[i].mv, tbl[i].jp, tbl[i].a1, tbl[i].a2, tbl[i].og);
            chk($sformatf("tbl%0d_state", i), anim_state, tbl[i].st);
            chk($sformatf("tbl%0d_frame", i), anim_frame, tbl[i].fr);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
            chk($sformatf("tbl%0d_active", i), atk_active, tbl[i].ac);
            chk($sformatf("tbl%0d_done", i), anim_done, tbl[i].dn);
        end

        // priority from WALK, then re-hit in HIT at counter 5
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        tk(1, 0, 0, 0, 1);
        chk("walk_state", anim_state, 1);
        tk(1, 1, 1, 1, 1);
        chk("prio_state", anim_state, 4);
        cyc(0, 1, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 15; k++) tk(0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 19; k++) tk(0, 0, 0, 0, 1);
        chk("rehit_still", anim_state, 5);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("rehit_exit", anim_state, 0);
        chk("rehit_done", anim_done, 1);

        // reset on a tick mid-attack with a hit pending
        tk(0, 0, 1, 0, 1);
        for (int k = 0; k < 5; k++) tk(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0, 1);
        chk("rst6_state", anim_state, 0);
        chk("rst6_frame", anim_frame, 0);
        chk("rst6_busy", busy, 0);
        chk("rst6_done", anim_done, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("rst6_idle", anim_state, 0);

        // randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(bit'($urandom_range(0, 299) == 0), bit'($urandom_range(0, 2) == 0),
                bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 9) == 0),
                bit'($urandom_range(0, 14) == 0), bit'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
